multicycle_alu: RTL and testbench

Parametrised successor of the datapath ALU. Adds a start/busy/done handshake and registered outputs. Logic and add ops complete in 1 cycle; multiply ops run on an iterative radix-2 shift-add engine and produce a full 2*WIDTH product (HI/LO).
Sits between the register-file read stage and the writeback mux. The control unit stalls the PC while busy=1.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/shift_add_mult.sv | 56 +++++
 rtl/multicycle_alu.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_alu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multicycle ALU:
//   - 4-bit operation codes (AND .. MULT); codes 9-15 are undefined
//   - FSM state encoding for the top-level controller
//   - is_multicycle(): true for ops that run on the shift-add engine
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_AND      = 4'd0;
  localparam logic [3:0] OP_OR       = 4'd1;
  localparam logic [3:0] OP_NOR      = 4'd2;
  localparam logic [3:0] OP_ADD      = 4'd3;
  localparam logic [3:0] OP_SUB      = 4'd4;
  localparam logic [3:0] OP_INC      = 4'd5;
  localparam logic [3:0] OP_MULTPLUS = 4'd6;
  localparam logic [3:0] OP_MOV      = 4'd7;
  localparam logic [3:0] OP_MULT     = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Multiply-class ops are the only ones that need the iterative engine.
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTPLUS);
  endfunction

endpackage

// File: rtl/shift_add_mult.sv
// ---------------------------------------------------------------------------
// shift_add_mult
// Iterative radix-2 unsigned shift-add multiplier. One partial-product step
// per clock while 'step' is high; after WIDTH steps 'product' holds a*b.
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-high reset
//   load    in   capture a (multiplicand) and b (multiplier), clear accumulator
//   step    in   perform one shift-add iteration
//   a, b    in   WIDTH-bit operands (sampled only on load)
//   product out  2*WIDTH-bit running/final product
// ---------------------------------------------------------------------------
module shift_add_mult #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     partial;

  // The product register doubles as the multiplier shift register: the low
  // half starts as b and is consumed LSB-first while the accumulator (high
  // half, plus a carry bit) grows and shifts down into it.
  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    partial = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    if (load) begin
      mcand_d = a;
      prod_d  = {{WIDTH{1'b0}}, b};
    end else if (step) begin
      prod_d = {partial, prod_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

  assign product = prod_q;

endmodule

// File: rtl/multicycle_alu.sv
// ---------------------------------------------------------------------------
// multicycle_alu
// ALU with start/busy/done handshake and registered outputs. Logic/add ops
// finish in one cycle; MULT/MULTPLUS run WIDTH steps on shift_add_mult and
// return a full 2*WIDTH product split into hi_result/alu_result.
// Optional build macro: MULTICYCLE_ALU_OVF_EN adds the 'ovf' output.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   start             request, only honoured in IDLE
//   alu_op, a, b      op code and operands, captured with start
//   busy              high while a multiply is iterating
//   done              one-cycle pulse when results are valid
//   alu_result        result (low half of product for multiply ops)
//   hi_result         high half of product, 0 for other ops
//   zero              alu_result == 0
//   ovf (optional)    signed overflow (ADD/SUB/INC) or hi_result != 0 (mult)
// ---------------------------------------------------------------------------
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] hi_result,
  output logic             zero
`ifdef MULTICYCLE_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   single_res;
  logic               mul_load, mul_step;
  logic [2*WIDTH-1:0] mul_product;
  logic [2*WIDTH-1:0] final_prod;
`ifdef MULTICYCLE_ALU_OVF_EN
  logic               ovf_q, ovf_d;
  logic               single_ovf;
`endif

  shift_add_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .step    (mul_step),
    .a       (a),
    .b       (b),
    .product (mul_product)
  );

  // MULTPLUS carry ripples through the full 2*WIDTH product into hi.
  assign final_prod = mul_product + {{(2*WIDTH-1){1'b0}}, (op_q == OP_MULTPLUS)};

  // Single-cycle datapath; undefined codes deliberately produce zero.
  always_comb begin
    single_res = '0;
    case (alu_op)
      OP_AND:  single_res = a & b;
      OP_OR:   single_res = a | b;
      OP_NOR:  single_res = ~(a | b);
      OP_ADD:  single_res = a + b;
      OP_SUB:  single_res = a - b;
      OP_INC:  single_res = a + WIDTH'(1);
      OP_MOV:  single_res = b;
      default: single_res = '0;
    endcase
  end

`ifdef MULTICYCLE_ALU_OVF_EN
  // Two's-complement overflow: operands' signs vs. result sign.
  always_comb begin
    single_ovf = 1'b0;
    case (alu_op)
      OP_ADD:  single_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (single_res[WIDTH-1] != a[WIDTH-1]);
      OP_SUB:  single_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (single_res[WIDTH-1] != a[WIDTH-1]);
      OP_INC:  single_ovf = !a[WIDTH-1] && single_res[WIDTH-1];
      default: single_ovf = 1'b0;
    endcase
  end
`endif

  // Controller. Single-cycle results are latched on the start edge; multiply
  // results are latched on the DONE edge, together with the done pulse, so
  // done always trails the DONE state by one register stage.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    done_d   = 1'b0;
    res_d    = res_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
`ifdef MULTICYCLE_ALU_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = alu_op;
          if (is_multicycle(alu_op)) begin
            mul_load = 1'b1;
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else begin
            res_d   = single_res;
            hi_d    = '0;
            zero_d  = (single_res == '0);
`ifdef MULTICYCLE_ALU_OVF_EN
            ovf_d   = single_ovf;
`endif
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
        if (is_multicycle(op_q)) begin
          res_d  = final_prod[WIDTH-1:0];
          hi_d   = final_prod[2*WIDTH-1:WIDTH];
          zero_d = (final_prod[WIDTH-1:0] == '0);
`ifdef MULTICYCLE_ALU_OVF_EN
          ovf_d  = (final_prod[2*WIDTH-1:WIDTH] != '0);
`endif
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b1;
`ifdef MULTICYCLE_ALU_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      done_q  <= done_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
`ifdef MULTICYCLE_ALU_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy       = (state_q == ST_MUL);
  assign done       = done_q;
  assign alu_result = res_q;
  assign hi_result  = hi_q;
  assign zero       = zero_q;
`ifdef MULTICYCLE_ALU_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// ---------------------------------------------------------------------------
// tb_multicycle_alu
// Directed self-checking bench for multicycle_alu (WIDTH=32). Expected values
// are hand-computed constants. Build with MULTICYCLE_ALU_OVF_EN defined to
// also exercise the ovf output.
// ---------------------------------------------------------------------------
module tb_multicycle_alu;

  localparam logic [3:0] OP_AND      = 4'd0;
  localparam logic [3:0] OP_OR       = 4'd1;
  localparam logic [3:0] OP_NOR      = 4'd2;
  localparam logic [3:0] OP_ADD      = 4'd3;
  localparam logic [3:0] OP_SUB      = 4'd4;
  localparam logic [3:0] OP_INC      = 4'd5;
  localparam logic [3:0] OP_MULTPLUS = 4'd6;
  localparam logic [3:0] OP_MOV      = 4'd7;
  localparam logic [3:0] OP_MULT     = 4'd8;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  aluOp;
  logic [31:0] aIn;
  logic [31:0] bIn;
  logic        busy;
  logic        done;
  logic [31:0] aluResult;
  logic [31:0] hiResult;
  logic        zero;
`ifdef MULTICYCLE_ALU_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;
  int bothHigh = 0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alu_op     (aluOp),
    .a          (aIn),
    .b          (bIn),
    .busy       (busy),
    .done       (done),
    .alu_result (aluResult),
    .hi_result  (hiResult),
    .zero       (zero)
`ifdef MULTICYCLE_ALU_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulses start for the edge that samples it, then follows the op until done
  // (bounded). lat counts edges after the start edge; busyCnt counts sampled
  // cycles with busy high. When injectAt matches, an ADD start is driven
  // for the following edge to probe that it is ignored.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] opA, input logic [31:0] opB,
                               input int injectAt, output int lat, output int busyCnt);
    @(negedge clk);
    start = 1'b1;
    aluOp = op;
    aIn   = opA;
    bIn   = opB;
    @(posedge clk);
    #1;
    start   = 1'b0;
    lat     = 0;
    busyCnt = 0;
    if (busy) busyCnt++;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busyCnt++;
      if (busy && done) bothHigh++;
      if (lat == injectAt) begin
        start = 1'b1;
        aluOp = OP_ADD;
        aIn   = 32'd1;
        bIn   = 32'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic watchDone(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
  endtask

  task automatic expectPulseEnds(input string tag);
    @(posedge clk);
    #1;
    checkOutput(tag, done, 0);
  endtask

  initial begin
    int lat;
    int busyCnt;
    int pulses;

    reset = 1'b1;
    start = 1'b0;
    aluOp = 4'd0;
    aIn   = '0;
    bIn   = '0;
    @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_result", aluResult, 0);
    checkOutput("rst_hi", hiResult, 0);
    checkOutput("rst_zero", zero, 1);
`ifdef MULTICYCLE_ALU_OVF_EN
    checkOutput("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // ADD: one-cycle latency, busy never seen
    applyStimulus(OP_ADD, 32'd5, 32'd10, -1, lat, busyCnt);
    checkOutput("add_result", aluResult, 32'd15);
    checkOutput("add_zero", zero, 0);
    checkOutput("add_hi", hiResult, 0);
    checkOutput("add_latency", lat, 1);
    checkOutput("add_busy_cycles", busyCnt, 0);
`ifdef MULTICYCLE_ALU_OVF_EN
    checkOutput("add_ovf", ovf, 0);
`endif
    expectPulseEnds("add_done_width");

    applyStimulus(OP_SUB, 32'd7, 32'd7, -1, lat, busyCnt);
    checkOutput("sub_result", aluResult, 32'd0);
    checkOutput("sub_zero", zero, 1);

    applyStimulus(OP_NOR, 32'd0, 32'd0, -1, lat, busyCnt);
    checkOutput("nor_result", aluResult, 32'hFFFF_FFFF);
    checkOutput("nor_zero", zero, 0);

    applyStimulus(OP_INC, 32'hFFFF_FFFF, 32'd0, -1, lat, busyCnt);
    checkOutput("inc_wrap_result", aluResult, 32'd0);
    checkOutput("inc_wrap_zero", zero, 1);

    applyStimulus(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, -1, lat, busyCnt);
    checkOutput("and_result", aluResult, 32'h0000_F000);
    applyStimulus(OP_OR, 32'h0000_F0F0, 32'h0000_FF00, -1, lat, busyCnt);
    checkOutput("or_result", aluResult, 32'h0000_FFF0);
    applyStimulus(OP_MOV, 32'hDEAD_BEEF, 32'h0000_1234, -1, lat, busyCnt);
    checkOutput("mov_result", aluResult, 32'h0000_1234);

    // MULT: 33-edge latency, 32 busy cycles
    applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'd2, -1, lat, busyCnt);
    checkOutput("mult_lo", aluResult, 32'hFFFF_FFFE);
    checkOutput("mult_hi", hiResult, 32'd1);
    checkOutput("mult_zero", zero, 0);
    checkOutput("mult_latency", lat, 33);
    checkOutput("mult_busy_cycles", busyCnt, 32);
`ifdef MULTICYCLE_ALU_OVF_EN
    checkOutput("mult_ovf", ovf, 1);
`endif
    expectPulseEnds("mult_done_width");

    applyStimulus(OP_MULTPLUS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat, busyCnt);
    checkOutput("multplus_lo", aluResult, 32'h0000_0002);
    checkOutput("multplus_hi", hiResult, 32'hFFFF_FFFE);
    checkOutput("multplus_latency", lat, 33);

    // Undefined op clears a nonzero hi/lo
    applyStimulus(4'hF, 32'd5, 32'd5, -1, lat, busyCnt);
    checkOutput("undef_result", aluResult, 32'd0);
    checkOutput("undef_hi", hiResult, 32'd0);
    checkOutput("undef_zero", zero, 1);

    applyStimulus(OP_MULT, 32'd3, 32'd5, -1, lat, busyCnt);
    checkOutput("mult_small_lo", aluResult, 32'd15);
    checkOutput("mult_small_hi", hiResult, 32'd0);

    // ADD start while MULT is busy must be ignored
    applyStimulus(OP_MULT, 32'd6, 32'd7, 5, lat, busyCnt);
    checkOutput("inject_busy_result", aluResult, 32'd42);
    checkOutput("inject_busy_latency", lat, 33);
    watchDone(40, pulses);
    checkOutput("inject_busy_extra_done", pulses, 0);
    checkOutput("inject_busy_result_hold", aluResult, 32'd42);

    // ADD start sampled in the DONE state must be ignored
    applyStimulus(OP_MULT, 32'd6, 32'd7, 32, lat, busyCnt);
    checkOutput("inject_done_result", aluResult, 32'd42);
    checkOutput("inject_done_latency", lat, 33);
    watchDone(40, pulses);
    checkOutput("inject_done_extra_done", pulses, 0);

    checkOutput("busy_done_overlap", bothHigh, 0);

    // Reset ten cycles into a MULT aborts it with no done pulse
    @(negedge clk);
    start = 1'b1;
    aluOp = OP_MULT;
    aIn   = 32'hFFFF_FFFF;
    bIn   = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checkOutput("abort_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_result", aluResult, 0);
    checkOutput("abort_hi", hiResult, 0);
    checkOutput("abort_zero", zero, 1);
    @(negedge clk);
    reset = 1'b0;
    watchDone(40, pulses);
    checkOutput("abort_no_done", pulses, 0);

`ifdef MULTICYCLE_ALU_OVF_EN
    applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'd1, -1, lat, busyCnt);
    checkOutput("ovf_add_result", aluResult, 32'h8000_0000);
    checkOutput("ovf_add_flag", ovf, 1);
    applyStimulus(OP_SUB, 32'h8000_0000, 32'd1, -1, lat, busyCnt);
    checkOutput("ovf_sub_result", aluResult, 32'h7FFF_FFFF);
    checkOutput("ovf_sub_flag", ovf, 1);
    applyStimulus(OP_AND, 32'hFFFF_FFFF, 32'h8000_0000, -1, lat, busyCnt);
    checkOutput("ovf_logic_flag", ovf, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
